// File: rtl/mu0_run_supervisor.sv
// Run controller for one or more MU0 cores: pulses their reset, confirms each one starts,
// then records the cycle on which each core halts, or flags a run that never finishes.
module mu0_run_supervisor #(
    parameter int unsigned N_CPU          = 1,
    parameter int unsigned RESET_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_CPU-1:0]         running,
    output logic [N_CPU-1:0]         cpu_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [N_CPU-1:0]         start_err,
    output logic [N_CPU-1:0]         halted,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [N_CPU*CNT_W-1:0]   halt_cycle
);

    localparam int unsigned RstCntW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [RstCntW-1:0] RstCntLast = RstCntW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CntLast    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CntOne     = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StCheck,
        StRun,
        StDone,
        StTimeout
    } state_e;

    state_e state_q, state_d;

    logic [RstCntW-1:0]       rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [N_CPU-1:0]         start_err_q, start_err_d;
    logic [N_CPU-1:0]         halted_q, halted_d;
    logic [N_CPU*CNT_W-1:0]   halt_cycle_q, halt_cycle_d;

    logic all_halted;
    logic count_at_limit;

    // A core that is not running this cycle counts as halted even before it is latched.
    assign all_halted     = &(halted_q | ~running);
    assign count_at_limit = (count_q == CntLast);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StTimeout: begin
                if (start) begin
                    state_d = StReset;
                end
            end
            StReset: begin
                if (rst_cnt_q == RstCntLast) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = (running == '0) ? StDone : StRun;
            end
            StRun: begin
                // A last halt on the final counted cycle still completes the run.
                if (all_halted) begin
                    state_d = StDone;
                end else if (count_at_limit) begin
                    state_d = StTimeout;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        cpu_rst = '0;
        busy    = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                cpu_rst = '1;
            end
            StReset: begin
                cpu_rst = '1;
                busy    = 1'b1;
            end
            StCheck, StRun: begin
                busy = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            StTimeout: begin
                timeout = 1'b1;
            end
            default: begin
                cpu_rst = '1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: reset counter, cycle counter and per-core status
    // ------------------------------------------------------------------
    always_comb begin
        rst_cnt_d    = rst_cnt_q;
        count_d      = count_q;
        start_err_d  = start_err_q;
        halted_d     = halted_q;
        halt_cycle_d = halt_cycle_q;
        unique case (state_q)
            StIdle, StDone, StTimeout: begin
                if (start) begin
                    rst_cnt_d    = '0;
                    count_d      = '0;
                    start_err_d  = '0;
                    halted_d     = '0;
                    halt_cycle_d = '0;
                end
            end
            StReset: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
            end
            StCheck: begin
                count_d = CntOne;
                for (int i = 0; i < int'(N_CPU); i++) begin
                    if (!running[i]) begin
                        start_err_d[i]                  = 1'b1;
                        halted_d[i]                     = 1'b1;
                        halt_cycle_d[i*CNT_W +: CNT_W]  = '0;
                    end
                end
            end
            StRun: begin
                for (int i = 0; i < int'(N_CPU); i++) begin
                    if (!halted_q[i] && !running[i]) begin
                        halted_d[i]                     = 1'b1;
                        halt_cycle_d[i*CNT_W +: CNT_W]  = count_q;
                    end
                end
                if (!all_halted && !count_at_limit && (count_q != '1)) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                rst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt_q    <= '0;
            count_q      <= '0;
            start_err_q  <= '0;
            halted_q     <= '0;
            halt_cycle_q <= '0;
        end else begin
            rst_cnt_q    <= rst_cnt_d;
            count_q      <= count_d;
            start_err_q  <= start_err_d;
            halted_q     <= halted_d;
            halt_cycle_q <= halt_cycle_d;
        end
    end

    assign start_err   = start_err_q;
    assign halted      = halted_q;
    assign cycle_count = count_q;
    assign halt_cycle  = halt_cycle_q;

endmodule

// File: tb/tb_mu0_run_supervisor.sv
// Directed bench for mu0_run_supervisor: a vector table of whole runs on a two-core instance
// plus hand-written sequences for reset pulse length, restart clearing and mid-run reset.
module tb_mu0_run_supervisor;

    localparam int unsigned N2 = 2;
    localparam int unsigned R2 = 3;
    localparam int unsigned T2 = 20;
    localparam int unsigned W2 = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Single-core instance with default timeout
    logic        start1;
    logic [0:0]  running1, cpu_rst1, start_err1, halted1;
    logic        busy1, done1, timeout1;
    logic [31:0] cycle_count1, halt_cycle1;

    // Two-core instance with a short timeout
    logic            start2;
    logic [1:0]      running2, cpu_rst2, start_err2, halted2;
    logic            busy2, done2, timeout2;
    logic [W2-1:0]   cycle_count2;
    logic [2*W2-1:0] halt_cycle2;

    mu0_run_supervisor dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .running    (running1),
        .cpu_rst    (cpu_rst1),
        .busy       (busy1),
        .done       (done1),
        .timeout    (timeout1),
        .start_err  (start_err1),
        .halted     (halted1),
        .cycle_count(cycle_count1),
        .halt_cycle (halt_cycle1)
    );

    mu0_run_supervisor #(
        .N_CPU         (N2),
        .RESET_CYCLES  (R2),
        .TIMEOUT_CYCLES(T2),
        .CNT_W         (W2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .running    (running2),
        .cpu_rst    (cpu_rst2),
        .busy       (busy2),
        .done       (done2),
        .timeout    (timeout2),
        .start_err  (start_err2),
        .halted     (halted2),
        .cycle_count(cycle_count2),
        .halt_cycle (halt_cycle2)
    );

    // Model cores: running while enabled and fewer than h cycles have passed since reset fell.
    int   m1 = 0;
    int   h1;
    logic en1;
    int   m2[2] = '{0, 0};
    int   h2[2];
    logic [1:0] en2;

    always @(posedge clk) begin
        if (cpu_rst1[0]) m1 <= 0;
        else if (m1 < 1000) m1 <= m1 + 1;
        for (int i = 0; i < 2; i++) begin
            if (cpu_rst2[i]) m2[i] <= 0;
            else if (m2[i] < 1000) m2[i] <= m2[i] + 1;
        end
    end

    always_comb begin
        running1    = '0;
        running1[0] = en1 && (m1 < h1);
        running2    = '0;
        for (int i = 0; i < 2; i++) running2[i] = en2[i] && (m2[i] < h2[i]);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic start_run2();
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_idle2(input string name);
        int k;
        k = 0;
        while (busy2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_idle"}, busy2, 0);
    endtask

    typedef struct {
        string      name;
        logic [1:0] en;
        int         h0;
        int         h1;
        logic       done;
        logic       tmo;
        logic [1:0] serr;
        logic [1:0] hlt;
        int         hc0;
        int         hc1;
        int         cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k;
        int busy_low;

        vecs[0] = '{"two_halt",       2'b11,   4,   9, 1'b1, 1'b0, 2'b00, 2'b11,  4,  9,  9};
        vecs[1] = '{"timeout",        2'b11, 100, 100, 1'b0, 1'b1, 2'b00, 2'b00,  0,  0, 19};
        vecs[2] = '{"cpu1_dead",      2'b01,   6, 100, 1'b1, 1'b0, 2'b10, 2'b11,  6,  0,  6};
        vecs[3] = '{"halt_at_limit",  2'b11,   3,  19, 1'b1, 1'b0, 2'b00, 2'b11,  3, 19, 19};
        vecs[4] = '{"none_started",   2'b00,   5,   5, 1'b1, 1'b0, 2'b11, 2'b11,  0,  0,  1};
        vecs[5] = '{"limit_one_hung", 2'b11,  19, 100, 1'b0, 1'b1, 2'b00, 2'b01, 19,  0, 19};
        vecs[6] = '{"first_cycle",    2'b11,   1,   1, 1'b1, 1'b0, 2'b00, 2'b11,  1,  1,  1};

        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        en1    = 1'b1;
        h1     = 100;
        en2    = 2'b11;
        h2     = '{100, 100};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cpu_rst2", cpu_rst2, 2'b11);
        chk("rst_busy2", busy2, 0);
        chk("rst_done2", done2, 0);
        chk("rst_timeout2", timeout2, 0);
        chk("rst_start_err2", start_err2, 0);
        chk("rst_halted2", halted2, 0);
        chk("rst_count2", cycle_count2, 0);
        chk("rst_halt_cycle2", halt_cycle2, 0);
        chk("rst_cpu_rst1", cpu_rst1, 1);
        chk("rst_busy1", busy1, 0);
        rst = 1'b0;

        // Single core, reset pulse of one cycle, halt five cycles after CHECK
        h1 = 5;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("one_busy", busy1, 1);
        k = 0;
        while (busy1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("one_idle", busy1, 0);
        chk("one_done", done1, 1);
        chk("one_timeout", timeout1, 0);
        chk("one_halted", halted1, 1);
        chk("one_halt_cycle", halt_cycle1, 5);
        chk("one_count", cycle_count1, 5);
        chk("one_start_err", start_err1, 0);

        // Reset pulse length, busy window and staggered halts
        en2 = 2'b11;
        h2  = '{4, 9};
        start_run2();
        chk("pulse_busy_start", busy2, 1);
        k = 0;
        while (cpu_rst2 == 2'b11 && k < 10) begin
            k++;
            @(negedge clk);
        end
        chk("pulse_len", k, 3);
        chk("pulse_busy_check", busy2, 1);
        repeat (5) @(negedge clk);
        chk("stagger_halted", halted2, 2'b01);
        chk("stagger_not_done", done2, 0);
        chk("stagger_count", cycle_count2, 5);
        busy_low = 0;
        k = 0;
        while (!done2 && k < 200) begin
            if (!busy2) busy_low++;
            @(negedge clk);
            k++;
        end
        chk("stagger_busy_held", busy_low, 0);
        chk("stagger_done", done2, 1);
        chk("stagger_busy_off", busy2, 0);
        chk("stagger_count_end", cycle_count2, 9);
        chk("stagger_halt_cycle", halt_cycle2, {8'd9, 8'd4});

        // Vector table of complete runs
        for (int v = 0; v < 7; v++) begin
            en2   = vecs[v].en;
            h2[0] = vecs[v].h0;
            h2[1] = vecs[v].h1;
            start_run2();
            wait_idle2(vecs[v].name);
            chk({vecs[v].name, "_done"}, done2, vecs[v].done);
            chk({vecs[v].name, "_timeout"}, timeout2, vecs[v].tmo);
            chk({vecs[v].name, "_start_err"}, start_err2, vecs[v].serr);
            chk({vecs[v].name, "_halted"}, halted2, vecs[v].hlt);
            chk({vecs[v].name, "_hc0"}, halt_cycle2[7:0], vecs[v].hc0);
            chk({vecs[v].name, "_hc1"}, halt_cycle2[15:8], vecs[v].hc1);
            chk({vecs[v].name, "_count"}, cycle_count2, vecs[v].cnt);
        end

        // Timeout with partial status, then a restart must clear everything
        en2 = 2'b11;
        h2  = '{5, 100};
        start_run2();
        wait_idle2("restart_first");
        chk("restart_first_timeout", timeout2, 1);
        chk("restart_first_halted", halted2, 2'b01);
        chk("restart_first_hc", halt_cycle2, {8'd0, 8'd5});
        h2 = '{2, 2};
        start_run2();
        chk("restart_timeout_clr", timeout2, 0);
        chk("restart_busy", busy2, 1);
        chk("restart_count_clr", cycle_count2, 0);
        chk("restart_halted_clr", halted2, 0);
        chk("restart_hc_clr", halt_cycle2, 0);
        wait_idle2("restart_second");
        chk("restart_done", done2, 1);
        chk("restart_count", cycle_count2, 2);

        // Start ignored mid-run, then synchronous reset at cycle_count 7
        h2 = '{3, 100};
        start_run2();
        repeat (8) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        chk("midrst_count", cycle_count2, 7);
        chk("midrst_halted", halted2, 2'b01);
        chk("midrst_hc0", halt_cycle2[7:0], 3);
        chk("midrst_busy", busy2, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cpu_rst", cpu_rst2, 2'b11);
        chk("midrst_busy_off", busy2, 0);
        chk("midrst_count_clr", cycle_count2, 0);
        chk("midrst_halted_clr", halted2, 0);
        chk("midrst_hc_clr", halt_cycle2, 0);
        chk("midrst_done", done2, 0);
        chk("midrst_timeout", timeout2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
